// File: rtl/tensor_slice_scheduler.sv
// Round-robin front end for one shared int8 tensor slice: accepts an operand pair,
// starts the slice, waits for done under a watchdog and returns the tagged C row.
module tensor_slice_scheduler #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned ID_W    = 2,
    parameter  int unsigned TIMEOUT = 63,
    localparam int unsigned OP_W    = 64,
    localparam int unsigned C_W     = 128,
    localparam int unsigned JOBS_W  = 16,
    localparam int unsigned TO_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a_data,
    input  logic [NUM_REQ*OP_W-1:0] req_b_data,
    output logic                    ts_start,
    output logic                    ts_pe_reset,
    output logic [OP_W-1:0]         ts_a_data,
    output logic [OP_W-1:0]         ts_b_data,
    input  logic                    ts_done,
    input  logic                    ts_c_avail,
    input  logic [C_W-1:0]          ts_c_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [C_W-1:0]          rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_error,
    output logic                    busy,
    output logic [JOBS_W-1:0]       jobs_done,
    output logic [TO_W-1:0]         timeouts
);

    localparam int unsigned TMR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_RECOVER
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_cur_id;
    logic [ID_W-1:0]     w_winner;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_req_ready;

    logic [OP_W-1:0]     r_a_data;
    logic [OP_W-1:0]     r_b_data;
    logic [OP_W-1:0]     w_sel_a;
    logic [OP_W-1:0]     w_sel_b;

    logic [TMR_W-1:0]    r_timer;
    logic [C_W-1:0]      r_rsp_data;
    logic                r_rsp_error;
    logic [JOBS_W-1:0]   r_jobs_done;
    logic [TO_W-1:0]     r_timeouts;

    logic                w_accept;
    logic                w_done_hit;
    logic                w_timeout_hit;
    logic                w_rsp_hs;

    // Round-robin pick: first valid requester after the last one served, with wrap
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!w_found && req_valid[i] &&
                    (((int'(r_last_grant) + k) % int'(NUM_REQ)) == i)) begin
                    w_found  = 1'b1;
                    w_winner = ID_W'(i);
                end
            end
        end
    end

    // Operand slice of the current winner
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a = req_a_data[i*OP_W +: OP_W];
                w_sel_b = req_b_data[i*OP_W +: OP_W];
            end
        end
    end

    // Grant is offered only while idle and out of reset
    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_req_ready[i] = (r_state == S_IDLE) && !reset && w_found &&
                             (w_winner == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_done_hit    = 1'b0;
        w_timeout_hit = 1'b0;
        w_rsp_hs      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Done with data wins over a coincident watchdog expiry
                if (ts_done && ts_c_avail) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_timer == TMR_W'(TIMEOUT)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operands and owner id, held until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_data <= '0;
            r_b_data <= '0;
            r_cur_id <= '0;
        end else if (w_accept) begin
            r_a_data <= w_sel_a;
            r_b_data <= w_sel_b;
            r_cur_id <= w_winner;
        end
    end

    // Watchdog timer: cleared while issuing, counts while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == S_ISSUE) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_timeouts  <= '0;
        end else if (w_done_hit) begin
            r_rsp_data  <= ts_c_data;
            r_rsp_error <= 1'b0;
        end else if (w_timeout_hit) begin
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b1;
            if (r_timeouts != '1) begin
                r_timeouts <= r_timeouts + TO_W'(1);
            end
        end
    end

    // Completion bookkeeping on response handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_jobs_done  <= '0;
        end else if (w_rsp_hs) begin
            r_last_grant <= r_cur_id;
            if (r_jobs_done != '1) begin
                r_jobs_done <= r_jobs_done + JOBS_W'(1);
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign ts_start    = (r_state == S_ISSUE);
    assign ts_pe_reset = reset || (r_state == S_RECOVER);
    assign ts_a_data   = r_a_data;
    assign ts_b_data   = r_b_data;
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_id      = r_cur_id;
    assign rsp_error   = r_rsp_error;
    assign busy        = (r_state != S_IDLE);
    assign jobs_done   = r_jobs_done;
    assign timeouts    = r_timeouts;

endmodule

// File: tb/tb_tensor_slice_scheduler.sv
// Directed bench for tensor_slice_scheduler: a job-timeline model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_tensor_slice_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 63;
    localparam int          TO      = 63;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_a_data;
    logic [NUM_REQ*64-1:0] req_b_data;
    logic                  ts_start;
    logic                  ts_pe_reset;
    logic [63:0]           ts_a_data;
    logic [63:0]           ts_b_data;
    logic                  ts_done;
    logic                  ts_c_avail;
    logic [127:0]          ts_c_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [127:0]          rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_error;
    logic                  busy;
    logic [15:0]           jobs_done;
    logic [7:0]            timeouts;

    logic                  sl_done;
    logic                  stray_done;
    logic                  stray_avail;
    logic [127:0]          sl_c;
    int                    sl_lat;
    int                    sl_cnt;
    bit                    sl_fixed_en;
    logic [127:0]          sl_fixed;

    assign ts_done    = sl_done | stray_done;
    assign ts_c_avail = sl_done | stray_avail;
    assign ts_c_data  = sl_c;

    tensor_slice_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a_data  (req_a_data),
        .req_b_data  (req_b_data),
        .ts_start    (ts_start),
        .ts_pe_reset (ts_pe_reset),
        .ts_a_data   (ts_a_data),
        .ts_b_data   (ts_b_data),
        .ts_done     (ts_done),
        .ts_c_avail  (ts_c_avail),
        .ts_c_data   (ts_c_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .jobs_done   (jobs_done),
        .timeouts    (timeouts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Slice stand-in: done (with data) sl_lat cycles after the start cycle; 0 = never
    initial begin
        sl_done = 1'b0;
        sl_c    = '0;
        sl_cnt  = 0;
        forever begin
            @(negedge clk);
            sl_done = 1'b0;
            if (ts_start === 1'b1 && sl_lat > 0) begin
                sl_cnt = sl_lat;
            end else if (sl_cnt > 0) begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    sl_done = 1'b1;
                    sl_c    = sl_fixed_en ? sl_fixed : {ts_a_data, ts_b_data};
                end
            end
        end
    end

    // Job-timeline model: age 0 is the start cycle; results appear one cycle after
    // done, or TIMEOUT+3 cycles after start when the watchdog fires.
    bit          m_in_job;
    int          m_age;
    int          m_resp_from;
    int          m_last;
    int          m_id;
    bit          m_err;
    logic [127:0] m_data;
    logic [63:0] m_a;
    logic [63:0] m_b;
    int          m_jobs;
    int          m_to;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        logic [NUM_REQ-1:0] sh;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            sh = v >> ((last + k) % int'(NUM_REQ));
            if (sh[0]) return (last + k) % int'(NUM_REQ);
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (reset) begin
            m_in_job    = 1'b0;
            m_age       = 0;
            m_resp_from = -1;
            m_last      = int'(NUM_REQ) - 1;
            m_id        = 0;
            m_err       = 1'b0;
            m_data      = '0;
            m_a         = '0;
            m_b         = '0;
            m_jobs      = 0;
            m_to        = 0;
        end else if (!m_in_job) begin
            w = rr_pick(req_valid, m_last);
            if (w >= 0) begin
                m_in_job    = 1'b1;
                m_age       = 0;
                m_id        = w;
                m_resp_from = -1;
                m_a         = 64'(req_a_data >> (w * 64));
                m_b         = 64'(req_b_data >> (w * 64));
            end
        end else begin
            if (m_resp_from < 0 && m_age >= 1 && m_age <= TO + 1) begin
                if (ts_done === 1'b1 && ts_c_avail === 1'b1) begin
                    m_resp_from = m_age + 1;
                    m_data      = ts_c_data;
                    m_err       = 1'b0;
                end else if (m_age == TO + 1) begin
                    m_resp_from = m_age + 2;
                    m_data      = '0;
                    m_err       = 1'b1;
                    if (m_to < 255) m_to++;
                end
            end else if (m_resp_from >= 0 && m_age >= m_resp_from && rsp_ready === 1'b1) begin
                m_in_job = 1'b0;
                m_last   = m_id;
                if (m_jobs < 65535) m_jobs++;
            end
            if (m_in_job) m_age++;
        end
    endtask

    task automatic check_outputs();
        int w;
        logic [NUM_REQ-1:0] exp_ready;
        bit exp_rv;
        bit exp_pe;
        exp_ready = '0;
        if (!reset && !m_in_job) begin
            w = rr_pick(req_valid, m_last);
            if (w >= 0) exp_ready = NUM_REQ'(1) << w;
        end
        exp_rv = m_in_job && m_resp_from >= 0 && m_age >= m_resp_from;
        exp_pe = reset || (m_in_job && m_err && m_resp_from == TO + 3 && m_age == TO + 2);
        chk("busy", 128'(busy), 128'(m_in_job));
        chk("req_ready", 128'(req_ready), 128'(exp_ready));
        chk("ts_start", 128'(ts_start), 128'(m_in_job && m_age == 0));
        chk("ts_pe_reset", 128'(ts_pe_reset), 128'(exp_pe));
        chk("ts_a_data", 128'(ts_a_data), 128'(m_a));
        chk("ts_b_data", 128'(ts_b_data), 128'(m_b));
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
        chk("jobs_done", 128'(jobs_done), 128'(m_jobs));
        chk("timeouts", 128'(timeouts), 128'(m_to));
        if (exp_rv) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", 128'(rsp_id), 128'(m_id));
            chk("rsp_error", 128'(rsp_error), 128'(m_err));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
        end
    end

    // Bounded wait at negedges: which 0 = ts_start, 1 = rsp_valid
    task automatic wait_for(input int which, input int max, input string nm);
        int k;
        k = 0;
        while (!((which == 0) ? (ts_start === 1'b1) : (rsp_valid === 1'b1))) begin
            if (k == max) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: not seen within %0d cycles", nm, max);
                return;
            end
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    logic [63:0]  a_v [4];
    logic [63:0]  b_v [4];
    int           exp_rr [5] = '{0, 1, 2, 3, 0};
    int           got [5];
    int           cs;
    int           cr;
    int           n_pe;
    logic [127:0] held_d;
    logic [ID_W-1:0] held_id;

    initial begin
        a_v = '{64'hA0A1_A2A3_A4A5_A6A7, 64'h1111_2222_3333_4444,
                64'h0102_0304_0506_0708, 64'hF0E0_D0C0_B0A0_9080};
        b_v = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h5555_AAAA_5555_AAAA,
                64'h0101_0101_0101_0101, 64'h7F80_7F80_7F80_7F80};
        reset       = 1'b1;
        req_valid   = '0;
        rsp_ready   = 1'b0;
        stray_done  = 1'b0;
        stray_avail = 1'b0;
        sl_lat      = 0;
        sl_fixed_en = 1'b0;
        sl_fixed    = '0;
        req_a_data  = {a_v[3], a_v[2], a_v[1], a_v[0]};
        req_b_data  = {b_v[3], b_v[2], b_v[1], b_v[0]};
        repeat (3) @(negedge clk);
        chk("rst_pe_reset", 128'(ts_pe_reset), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single job on requester 2, slice answers 34 cycles after start
        sl_lat      = 34;
        sl_fixed_en = 1'b1;
        sl_fixed    = 128'h0024_0024_0024_0024_0024_0024_0024_0024;
        rsp_ready   = 1'b1;
        req_valid   = 4'b0100;
        wait_for(0, 10, "t1_start");
        cs = cyc;
        chk("t1_operand_a", 128'(ts_a_data), 128'h0102_0304_0506_0708);
        @(negedge clk);
        chk("t1_start_single", 128'(ts_start), 128'd0);
        repeat (9) @(negedge clk);
        stray_done  = 1'b1;
        stray_avail = 1'b0;
        @(negedge clk);
        stray_done  = 1'b0;
        wait_for(1, 100, "t1_rsp");
        cr = cyc;
        chk("t1_latency", 128'(cr - cs), 128'd35);
        chk("t1_id", 128'(rsp_id), 128'd2);
        chk("t1_data", rsp_data, 128'h0024_0024_0024_0024_0024_0024_0024_0024);
        chk("t1_error", 128'(rsp_error), 128'd0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("t1_jobs", 128'(jobs_done), 128'd1);
        sl_fixed_en = 1'b0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Round robin with every requester valid
        sl_lat    = 5;
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_for(1, 50, "rr_rsp");
            got[j] = int'(rsp_id);
            if (j == 4) req_valid = '0;
            @(negedge clk);
        end
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", 128'(got[j]), 128'(exp_rr[j]));
        end
        chk("rr_jobs", 128'(jobs_done), 128'd5);

        // Backpressure: response held for 10 cycles with other requesters waiting
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        wait_for(1, 50, "bp_rsp");
        held_d  = rsp_data;
        held_id = rsp_id;
        chk("bp_id", 128'(rsp_id), 128'd1);
        chk("bp_data", rsp_data, {a_v[1], b_v[1]});
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("bp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_id_hold", 128'(rsp_id), 128'(held_id));
            chk("bp_data_hold", rsp_data, held_d);
            chk("bp_no_start", 128'(ts_start), 128'd0);
            chk("bp_no_ready", 128'(req_ready), 128'd0);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_jobs", 128'(jobs_done), 128'd6);

        // Watchdog timeout: slice never answers
        sl_lat    = 0;
        req_valid = 4'b0001;
        wait_for(0, 10, "to_start");
        cs   = cyc;
        n_pe = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ts_pe_reset === 1'b1) n_pe++;
            if (rsp_valid === 1'b1) break;
        end
        cr = cyc;
        chk("to_rsp_valid", 128'(rsp_valid), 128'd1);
        chk("to_latency", 128'(cr - cs), 128'd66);
        chk("to_pe_pulses", 128'(n_pe), 128'd1);
        chk("to_error", 128'(rsp_error), 128'd1);
        chk("to_data", rsp_data, 128'd0);
        chk("to_id", 128'(rsp_id), 128'd0);
        chk("to_count", 128'(timeouts), 128'd1);
        req_valid = '0;
        @(negedge clk);

        // Done arrives on the very cycle the watchdog expires
        sl_lat    = TO + 1;
        req_valid = 4'b0001;
        wait_for(0, 10, "co_start");
        cs = cyc;
        wait_for(1, 100, "co_rsp");
        cr = cyc;
        chk("co_latency", 128'(cr - cs), 128'd65);
        chk("co_error", 128'(rsp_error), 128'd0);
        chk("co_data", rsp_data, {a_v[0], b_v[0]});
        chk("co_count", 128'(timeouts), 128'd1);
        req_valid = '0;
        @(negedge clk);

        // Reset in WAIT, then a stray done while idle
        sl_lat    = 0;
        req_valid = 4'b0100;
        wait_for(0, 10, "mr_start");
        repeat (5) @(negedge clk);
        chk("mr_busy_before", 128'(busy), 128'd1);
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_busy", 128'(busy), 128'd0);
        chk("mr_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("mr_jobs", 128'(jobs_done), 128'd0);
        chk("mr_timeouts", 128'(timeouts), 128'd0);
        chk("mr_operand", 128'(ts_a_data), 128'd0);
        stray_done  = 1'b1;
        stray_avail = 1'b1;
        @(negedge clk);
        stray_done  = 1'b0;
        stray_avail = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("sd_rsp_valid", 128'(rsp_valid), 128'd0);
            chk("sd_busy", 128'(busy), 128'd0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tensor_slice_scheduler.md
Name: tensor_slice_scheduler

Overview:
Arbitrates NUM_REQ requesters sharing one int8 tensor slice. It accepts a 64-bit A-row / B-column operand pair from the round-robin winner and pulses the slice start. It then waits for slice done (with a watchdog timeout) and returns the 128-bit C row tagged with the requester id. It sits between the request fabric and the tensor slice's start/done/data ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester id; must equal clog2(NUM_REQ), minimum 1
TIMEOUT, 63, cycles in WAIT with no done before abort (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a_data  in  NUM_REQ*64  requester i A row at [i*64 +: 64]
req_b_data  in  NUM_REQ*64  requester i B column at [i*64 +: 64]
ts_start  out  1  start_mat_mul pulse to slice
ts_pe_reset  out  1  pe_reset to slice
ts_a_data  out  64  operand A to slice
ts_b_data  out  64  operand B to slice
ts_done  in  1  done_mat_mul from slice
ts_c_avail  in  1  c_data_available from slice
ts_c_data  in  128  c_data_out from slice
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_data  out  128  captured C row
rsp_id  out  ID_W  requester that owns rsp_data
rsp_error  out  1  1 = job aborted by timeout; rsp_data is 0
busy  out  1  high in any state other than IDLE
jobs_done  out  16  count of completed jobs (error or not), saturates at 16'hFFFF
timeouts  out  8  count of timeout aborts, saturates at 8'hFF

Behaviour:
- Reset: state=IDLE; last_grant=NUM_REQ-1; all outputs 0 except ts_pe_reset=1 while reset is high. Operand, result and counter registers clear to 0. A reset during ISSUE/WAIT/RESP aborts the job with no response.
- States: IDLE, ISSUE, WAIT, RESP, RECOVER.
- IDLE: the winner is the first requester with req_valid=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[winner]=1 combinationally in IDLE only; all other bits are 0.
  - On handshake, latch req_a_data/req_b_data slices into the operand registers and the winner into cur_id, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: ts_start=1 for exactly this one cycle; timer cleared to 0; go to WAIT.
- ts_a_data/ts_b_data are driven from the operand registers and held stable until the next accept.
- WAIT: timer increments each cycle.
  - If ts_done=1 and ts_c_avail=1: rsp_data<=ts_c_data, rsp_error<=0, go to RESP.
  - Else if timer==TIMEOUT: rsp_data<=0, rsp_error<=1, timeouts+1 (saturating), go to RECOVER.
  - If done and timeout coincide, done wins.
  - ts_done=1 with ts_c_avail=0 is ignored.
- RECOVER: ts_pe_reset=1 for one cycle, then go to RESP.
- RESP: rsp_valid=1; rsp_data, rsp_id=cur_id and rsp_error are held stable until rsp_ready=1.
  - On handshake: last_grant<=cur_id, jobs_done+1 (saturating), go to IDLE.
  - rsp_valid deasserts the following cycle.
- ts_done seen outside WAIT is ignored. Only one job is in flight at a time.
- Latency: accept at cycle T, ts_start at T+1, rsp_valid in the cycle after ts_done is sampled in WAIT. A new accept cannot occur before the cycle after the response handshake.
- Fairness: a continuously valid requester is served within NUM_REQ jobs.

Test Plan:
- Single job: requester 2 with a_data=64'h0102030405060708, b_data=64'h01..01; the slice model returns c_data=128'h0024_0024... 34 cycles after start. Expect exactly one ts_start pulse at T+1, and rsp_valid one cycle after done with rsp_id=2, rsp_error=0 and the data matching.
- Round-robin: all 4 req_valid held high. Expect grant order 0,1,2,3,0 and jobs_done=5 after five responses.
- Backpressure: hold rsp_ready=0 for 10 cycles. Expect rsp_valid/rsp_data/rsp_id stable, req_ready=0 throughout, and no second ts_start.
- Timeout: the slice never asserts done and TIMEOUT=63. Expect a one-cycle ts_pe_reset pulse, then rsp_valid with rsp_error=1, rsp_data=0, timeouts=1.
- Coincident done and timeout: ts_done asserted on the cycle timer==TIMEOUT. Expect rsp_error=0, data captured, timeouts unchanged.
- Mid-job reset and stray done: assert reset in WAIT. Expect IDLE, rsp_valid=0, counters 0. Then a ts_done pulse while in IDLE produces no response.
